// File: rtl/rgb_pkg.sv
// rgb_pkg: palette indices and colour lookup shared by the colour cycler
package rgb_pkg;
  localparam int MAX_COLORS = 8;
  localparam logic [2:0] IDX_WHITE   = 3'd0;
  localparam logic [2:0] IDX_RED     = 3'd1;
  localparam logic [2:0] IDX_GREEN   = 3'd2;
  localparam logic [2:0] IDX_BLUE    = 3'd3;
  localparam logic [2:0] IDX_YELLOW  = 3'd4;
  localparam logic [2:0] IDX_CYAN    = 3'd5;
  localparam logic [2:0] IDX_MAGENTA = 3'd6;
  localparam logic [2:0] IDX_OFF     = 3'd7;
  localparam logic [7:0] R_MASK = 8'((1 << IDX_WHITE) | (1 << IDX_RED) | (1 << IDX_YELLOW) | (1 << IDX_MAGENTA));
  localparam logic [7:0] G_MASK = 8'((1 << IDX_WHITE) | (1 << IDX_GREEN) | (1 << IDX_YELLOW) | (1 << IDX_CYAN));
  localparam logic [7:0] B_MASK = 8'((1 << IDX_WHITE) | (1 << IDX_BLUE) | (1 << IDX_CYAN) | (1 << IDX_MAGENTA));
  function automatic logic [95:0] palette_rgb(input logic [2:0] idx, input int level, input int ch_w);
    logic [95:0] l;
    l = 96'(level);
    return idx == IDX_OFF ? '0 : (R_MASK[idx] ? l << (2 * ch_w) : '0) | (G_MASK[idx] ? l << ch_w : '0) | (B_MASK[idx] ? l : '0);
  endfunction
endpackage

// File: rtl/rgb_color_cycler_button_debounce.sv
// button_debounce: 2-FF synchroniser, stable-count debouncer and rising-edge pulse
module button_debounce #(
  parameter int DEBOUNCE_CYC = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise_pulse
);
  localparam int CW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
  logic [1:0] sync_q, sync_d;
  logic db_q, db_d, accept;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d = {sync_q[0], raw};
    accept = sync_q[1] != db_q && cnt_q == CW'(DEBOUNCE_CYC - 1);
    db_d = accept ? sync_q[1] : db_q;
    cnt_d = (sync_q[1] == db_q || accept) ? '0 : cnt_q + 1'b1;
    rise_pulse = accept && sync_q[1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      db_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      db_q <= db_d;
      cnt_q <= cnt_d;
    end
  end
  assign stable = db_q;
endmodule

// File: rtl/rgb_color_cycler.sv
// rgb_color_cycler: two-button palette stepper with auto-cycle timer and optional per-channel ramp
module rgb_color_cycler
  import rgb_pkg::*;
#(
  parameter int CH_W         = 8,
  parameter int N_COLORS     = 4,
  parameter int LEVEL        = 2 ** (CH_W - 1) - 1,
  parameter int DEBOUNCE_CYC = 12000,
  parameter int AUTO_PERIOD  = 12000000,
  parameter int RAMP_DIV     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        button,
  output logic [3*CH_W-1:0] RGBcolor,
  output logic [2:0]        color_idx,
  output logic              auto_mode
);
  localparam int AW = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;
  localparam int RW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam logic [2:0] LAST = 3'(N_COLORS - 1);
  if (N_COLORS < 2 || N_COLORS > MAX_COLORS) begin : g_bad_n
    $error("N_COLORS out of range");
  end
  logic [1:0] press, unused_stable;
  logic [2:0] idx_q, idx_d;
  logic auto_q, auto_d, tick, pulse;
  logic [AW-1:0] tmr_q, tmr_d;
  logic [RW-1:0] pre_q, pre_d;
  logic [3*CH_W-1:0] rgb_q, rgb_d, target;
  for (genvar b = 0; b < 2; b++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk(clk), .rst_n(rst_n), .raw(button[b]), .stable(unused_stable[b]), .rise_pulse(press[b])
    );
  end
  always_comb begin
    tick = auto_q && tmr_q == AW'(AUTO_PERIOD - 1);
    idx_d = (press[0] || tick) ? (idx_q == LAST ? '0 : idx_q + 3'd1) : idx_q;
    auto_d = auto_q ^ press[1];
    tmr_d = (press[1] || (press[0] && auto_q) || tick) ? '0 : auto_q ? tmr_q + 1'b1 : tmr_q;
    pulse = RAMP_DIV == 0 || pre_q == RW'(RAMP_DIV - 1);
    pre_d = pulse ? '0 : pre_q + 1'b1;
    target = (3 * CH_W)'(palette_rgb(idx_q, LEVEL, CH_W));
    rgb_d = rgb_q;
    for (int c = 0; c < 3; c++)
      rgb_d[c*CH_W +: CH_W] = RAMP_DIV == 0 ? target[c*CH_W +: CH_W]
        : !pulse ? rgb_q[c*CH_W +: CH_W]
        : rgb_q[c*CH_W +: CH_W] < target[c*CH_W +: CH_W] ? rgb_q[c*CH_W +: CH_W] + 1'b1
        : rgb_q[c*CH_W +: CH_W] > target[c*CH_W +: CH_W] ? rgb_q[c*CH_W +: CH_W] - 1'b1
        : rgb_q[c*CH_W +: CH_W];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      auto_q <= 1'b0;
      tmr_q <= '0;
      pre_q <= '0;
      rgb_q <= {3{CH_W'(LEVEL)}};
    end else begin
      idx_q <= idx_d;
      auto_q <= auto_d;
      tmr_q <= tmr_d;
      pre_q <= pre_d;
      rgb_q <= rgb_d;
    end
  end
  assign RGBcolor = rgb_q;
  assign color_idx = idx_q;
  assign auto_mode = auto_q;
endmodule

// File: tb/tb_rgb_color_cycler.sv
// tb_rgb_color_cycler: three configurations checked every cycle against a behavioural model
`timescale 1ns/1ps
module tb_rgb_color_cycler;
  localparam int DEB = 4;
  localparam int AP = 16;
  localparam logic [23:0] PAL [8] = '{24'h7F7F7F, 24'h7F0000, 24'h007F00, 24'h00007F,
                                      24'h7F7F00, 24'h007F7F, 24'h7F007F, 24'h000000};
  localparam logic [23:0] E4 [8] = '{24'h7F0000, 24'h007F00, 24'h00007F, 24'h7F7F7F,
                                     24'h7F0000, 24'h007F00, 24'h00007F, 24'h7F7F7F};
  localparam logic [23:0] E8 [8] = '{24'h7F0000, 24'h007F00, 24'h00007F, 24'h7F7F00,
                                     24'h007F7F, 24'h7F007F, 24'h000000, 24'h7F7F7F};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] button = 2'b00;
  logic [23:0] rgb [3];
  logic [2:0] idx [3];
  logic am [3];
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %h expected %h", name, inst, $time, got, want);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int NC = g == 1 ? 8 : 4;
    localparam int RD = g == 2 ? 2 : 0;
    rgb_color_cycler #(.CH_W(8), .N_COLORS(NC), .DEBOUNCE_CYC(DEB), .AUTO_PERIOD(AP), .RAMP_DIV(RD)) dut (
      .clk(clk), .rst_n(rst_n), .button(button), .RGBcolor(rgb[g]), .color_idx(idx[g]), .auto_mode(am[g])
    );
    int s1 [2], s2 [2], run [2], db [2];
    int m_idx, m_auto, m_tmr, m_cyc;
    logic [23:0] m_rgb;
    always @(posedge clk) begin
      int p [2];
      bit tick;
      logic [23:0] tgt;
      if (!rst_n) begin
        for (int b = 0; b < 2; b++) begin
          s1[b] = 0; s2[b] = 0; run[b] = 0; db[b] = 0;
        end
        m_idx = 0; m_auto = 0; m_tmr = 0; m_cyc = 0;
        m_rgb = PAL[0];
      end else begin
        for (int b = 0; b < 2; b++) begin
          p[b] = 0;
          if (s2[b] != db[b]) begin
            run[b]++;
            if (run[b] == DEB) begin
              db[b] = s2[b]; run[b] = 0; p[b] = db[b];
            end
          end else run[b] = 0;
        end
        tick = m_auto != 0 && m_tmr == AP - 1;
        tgt = PAL[m_idx];
        if (RD == 0) m_rgb = tgt;
        else if (m_cyc % RD == RD - 1)
          for (int c = 0; c < 3; c++) begin
            int cur, t;
            cur = int'(m_rgb[8*c +: 8]);
            t = int'(tgt[8*c +: 8]);
            m_rgb[8*c +: 8] = 8'(cur + int'(t > cur) - int'(t < cur));
          end
        m_cyc++;
        if (p[0] != 0 || tick) m_idx = (m_idx + 1) % NC;
        if (p[1] != 0 || (p[0] != 0 && m_auto != 0) || tick) m_tmr = 0;
        else if (m_auto != 0) m_tmr++;
        if (p[1] != 0) m_auto = 1 - m_auto;
        for (int b = 0; b < 2; b++) begin
          s2[b] = s1[b]; s1[b] = int'(button[b]);
        end
      end
    end
    always @(negedge clk) if (chk_en) begin
      chk("model_rgb", g, 32'(rgb[g]), 32'(m_rgb));
      chk("model_idx", g, 32'(idx[g]), 32'(m_idx));
      chk("model_auto", g, 32'(am[g]), 32'(m_auto));
    end
  end

  task automatic press(input int b, input int n);
    button[b] = 1'b1;
    repeat (n) @(negedge clk);
    button[b] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic timed_press(input int b, input int at_acc, input int at_tick);
    button[b] = 1'b1;
    repeat (6) @(negedge clk);
    chk("acc_idx", 0, 32'(idx[0]), 32'(at_acc));
    chk("acc_auto", 0, 32'(am[0]), 32'd1);
    repeat (4) @(negedge clk);
    button[b] = 1'b0;
    repeat (11) @(negedge clk);
    chk("hold_idx", 0, 32'(idx[0]), 32'(at_acc));
    @(negedge clk);
    chk("tick_idx", 0, 32'(idx[0]), 32'(at_tick));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("reset_rgb", 0, 32'(rgb[0]), 32'h7F7F7F);
    chk("reset_idx", 0, 32'(idx[0]), 32'd0);
    chk("reset_auto", 0, 32'(am[0]), 32'd0);
    button[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("lat_before", 0, 32'(idx[0]), 32'd0);
    @(negedge clk);
    chk("lat_idx", 0, 32'(idx[0]), 32'd1);
    chk("lat_rgb_lag", 0, 32'(rgb[0]), 32'h7F7F7F);
    @(negedge clk);
    chk("lat_rgb", 0, 32'(rgb[0]), 32'h7F0000);
    repeat (3) @(negedge clk);
    button[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("man4_rgb", 0, 32'(rgb[0]), 32'(E4[0]));
    chk("man8_rgb", 1, 32'(rgb[1]), 32'(E8[0]));
    for (int i = 1; i < 8; i++) begin
      press(0, 10);
      chk("man4_rgb", 0, 32'(rgb[0]), 32'(E4[i]));
      chk("man8_rgb", 1, 32'(rgb[1]), 32'(E8[i]));
    end
    press(0, 3);
    chk("glitch_idx4", 0, 32'(idx[0]), 32'd0);
    chk("glitch_idx8", 1, 32'(idx[1]), 32'd0);
    timed_press(1, 0, 1);
    repeat (10) @(negedge clk);
    timed_press(0, 2, 3);
    press(1, 10);
    chk("auto_off", 0, 32'(am[0]), 32'd0);
    repeat (300) begin
      button = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    button = 2'b00;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ramp_start", 2, 32'(rgb[2]), 32'h7F7F7F);
    press(0, 10);
    repeat (260) @(negedge clk);
    chk("ramp_done", 2, 32'(rgb[2]), 32'h7F0000);
    press(0, 10);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("ramp_rst_rgb", 2, 32'(rgb[2]), 32'h7F7F7F);
    chk("ramp_rst_idx", 2, 32'(idx[2]), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
